// File: rtl/button_event_array.sv
// Multi-channel button front end: 2-FF sync, debounce, press/release/long-press pulses.
// Define BUTTON_EVENT_AUTOREPEAT_EN to make long_pulse re-fire every REPEAT_CNT cycles while held.

module button_event_channel #(
  parameter int unsigned      CNT_W      = 20,
  parameter logic [CNT_W-1:0] DEB_CNT    = 20'd200000,
  parameter logic [CNT_W-1:0] LONG_CNT   = 20'd500000
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  ,
  parameter logic [CNT_W-1:0] REPEAT_CNT = 20'd100000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = DEB_CNT - 1'b1;
  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CNT - 1'b1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] db_cnt;
  logic             btn_d;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_hit;
  hold_state_e      state;
  hold_state_e      state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Any cycle agreeing with the accepted level restarts the count, so only an
  // unbroken run of DEB_CNT disagreeing samples flips btn_level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (sync2 == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DEB_LAST) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_d         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      btn_d         <= btn_level;
      press_pulse   <= btn_level & ~btn_d;
      release_pulse <= ~btn_level & btn_d;
    end
  end

  assign hold_hit = (hold_cnt == LONG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (release_pulse) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (press_pulse) state_nxt = HELD;
        HELD:    if (hold_hit) state_nxt = LONG;
        LONG:    state_nxt = LONG;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Held at zero while idle, so HELD always starts counting from 0; frozen once LONG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (state == HELD && state_nxt == HELD) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = REPEAT_CNT - 1'b1;

  logic [CNT_W-1:0] rep_cnt;
  logic             rep_hit;

  assign rep_hit = (rep_cnt == REP_LAST);

  // Period is measured from the previous long_pulse: clear on LONG entry, on each repeat and on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (state != LONG || state_nxt != LONG || rep_hit) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`endif

  // A release landing on the threshold (or a repeat) cycle wins and suppresses the pulse.
  always_comb begin
    long_pulse = 1'b0;
    if (!release_pulse) begin
      case (state)
        HELD:    long_pulse = hold_hit;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        LONG:    long_pulse = rep_hit;
`endif
        default: long_pulse = 1'b0;
      endcase
    end
  end

endmodule

module button_event_array #(
  parameter int unsigned      CH         = 4,
  parameter int unsigned      CNT_W      = 20,
  parameter logic [CNT_W-1:0] DEB_CNT    = 20'd200000,
  parameter logic [CNT_W-1:0] LONG_CNT   = 20'd500000,
  parameter logic [CNT_W-1:0] REPEAT_CNT = 20'd100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] btn_in,
  output logic [CH-1:0] btn_level,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] release_pulse,
  output logic [CH-1:0] long_pulse
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    button_event_channel #(
      .CNT_W      (CNT_W),
      .DEB_CNT    (DEB_CNT),
      .LONG_CNT   (LONG_CNT)
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
      ,
      .REPEAT_CNT (REPEAT_CNT)
`endif
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_raw       (btn_in[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_event_array.sv
// Randomised + directed bench for button_event_array against a sample-window reference model.
// The model follows BUTTON_EVENT_AUTOREPEAT_EN the same way the design does.
`timescale 1ns/1ps

module tb_button_event_array;

  localparam int CH    = 2;
  localparam int CNT_W = 20;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int REP   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] long_pulse;

  int total = 0;
  int bad   = 0;

  button_event_array #(
    .CH         (CH),
    .CNT_W      (CNT_W),
    .DEB_CNT    (20'd4),
    .LONG_CNT   (20'd20),
    .REPEAT_CNT (20'd8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples per edge; the level flips when the DEB samples
  // that have crossed the synchroniser all disagree with it.
  int            cyc;
  logic [CH-1:0] samp[$];
  logic [CH-1:0] m_level, m_level_d, m_press, m_release, m_long, m_active;
  int            press_edge[CH];

  task automatic modelReset();
    samp.delete();
    for (int k = 0; k < DEB + 2; k++) samp.push_back('0);
    m_level = '0; m_level_d = '0; m_press = '0; m_release = '0; m_long = '0; m_active = '0;
    for (int c = 0; c < CH; c++) press_edge[c] = 0;
  endtask

  task automatic modelStep();
    logic [CH-1:0] new_level;
    cyc++;
    samp.push_back(btn_in);
    void'(samp.pop_front());
    m_press   = m_level & ~m_level_d;
    m_release = ~m_level & m_level_d;
    new_level = m_level;
    for (int c = 0; c < CH; c++) begin
      bit all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (samp[k][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) new_level[c] = ~m_level[c];
    end
    m_level_d = m_level;
    m_level   = new_level;
    for (int c = 0; c < CH; c++) begin
      m_long[c] = 1'b0;
      if (m_active[c]) begin
        int d = cyc - press_edge[c];
        bit hit = (d == LONG);
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        if (d > LONG && ((d - LONG) % REP) == 0) hit = 1'b1;
`endif
        if (hit && !m_release[c]) m_long[c] = 1'b1;
        if (m_release[c]) m_active[c] = 1'b0;
      end
      if (m_press[c]) begin
        m_active[c]   = 1'b1;
        press_edge[c] = cyc;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic compareAll();
    checkOutput("btn_level", btn_level, m_level);
    checkOutput("press_pulse", press_pulse, m_press);
    checkOutput("release_pulse", release_pulse, m_release);
    checkOutput("long_pulse", long_pulse, m_long);
  endtask

  // Called at a negedge: drives val for n cycles, stepping the model at each posedge.
  task automatic applyStimulus(input logic [CH-1:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      btn_in = val;
      @(posedge clk);
      if (rst_n) modelStep();
      @(negedge clk);
      compareAll();
    end
  endtask

  // Asynchronous reset pulse starting mid-cycle, held for the given number of cycles.
  task automatic midReset(input logic [CH-1:0] val, input int n);
    #2 rst_n = 1'b0;
    modelReset();
    #1 compareAll();
    @(negedge clk);
    applyStimulus(val, n);
    rst_n = 1'b1;
  endtask

  initial begin
    int pe;
    bit seen;
    cyc = 0;
    modelReset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compareAll();
    rst_n = 1'b1;
    applyStimulus(2'b00, 3);

    // Long hold on channel 0, then a sub-threshold glitch on channel 1.
    applyStimulus(2'b01, 50);
    applyStimulus(2'b00, 15);
    applyStimulus(2'b10, 3);
    applyStimulus(2'b00, 12);

    // Release timed so release_pulse lands on the long threshold cycle.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus(2'b01, 1);
      if (m_press[0]) seen = 1'b1;
    end
    checkOutput("wait_press", {{(CH-1){1'b0}}, seen}, {{(CH-1){1'b0}}, 1'b1});
    pe = cyc;
    applyStimulus(2'b01, pe + (LONG - DEB - 2 - 1) - cyc);
    applyStimulus(2'b00, 15);

    // Both channels together.
    applyStimulus(2'b11, 30);
    applyStimulus(2'b00, 15);

    // Reset while channel 0 is in HELD and still pressed afterwards.
    applyStimulus(2'b01, 14);
    midReset(2'b01, 3);
    applyStimulus(2'b01, 40);
    applyStimulus(2'b00, 15);

    // Random bursts, with one extra asynchronous reset part way through.
    for (int b = 0; b < 60; b++) begin
      applyStimulus(CH'($urandom_range(0, 3)), int'($urandom_range(1, 30)));
      if (b == 30) midReset(CH'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end
    applyStimulus(2'b00, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
